// File: rtl/matriz_pkg.sv
// Shared definitions for the 5x5 matrix datapath: multiplier, writer-side loader and result reader.
// Element (r,c) of a flattened matrix sits at bit offset ELEM_W*(c + DIM*r), row-major.
package matriz_pkg;

   localparam int DIM    = 5;
   localparam int ELEM_W = 8;
   localparam int MAT_W  = DIM * DIM * ELEM_W;
   localparam int IDX_W  = $clog2(MAT_W);
   localparam int CKS_W  = 16;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      SEND = 2'd1,
      FIM  = 2'd2
   } estado_t;

   function automatic logic [IDX_W-1:0] indice(input logic [2:0] linha,
                                               input logic [2:0] coluna);
      return IDX_W'(ELEM_W * (int'(coluna) + DIM * int'(linha)));
   endfunction

endpackage

// File: rtl/matriz_elem_sel.sv
// Combinational element selector: picks element (linha, coluna) out of a flattened matrix.
// Shared with the loader; indices are expected to stay inside 0..DIM-1.
module matriz_elem_sel
   import matriz_pkg::*;
(
   input  logic [MAT_W-1:0]         buffer,
   input  logic [2:0]               linha,
   input  logic [2:0]               coluna,
   output logic signed [ELEM_W-1:0] elem
);

   logic [IDX_W-1:0] idx;

   assign idx  = indice(linha, coluna);
   assign elem = buffer[idx +: ELEM_W];

endmodule

// File: rtl/matriz_leitor_serial.sv
// Captures a flattened 5x5 result matrix on start and streams the active NxN block row-major
// over valid/ready. Define CHECKSUM_EN to add a 16-bit running sum of the transferred elements.
module matriz_leitor_serial
   import matriz_pkg::*;
(
   input  logic                     clock,
   input  logic                     reset_n,
   input  logic                     start,
   input  logic [MAT_W-1:0]         matriz_in,
   input  logic [7:0]               tamanho,
   output logic                     busy,
   output logic                     out_valid,
   input  logic                     out_ready,
   output logic signed [ELEM_W-1:0] out_data,
   output logic [2:0]               out_linha,
   output logic [2:0]               out_coluna,
   output logic                     out_last,
   output logic                     done,
   output logic                     erro
`ifdef CHECKSUM_EN
   ,
   output logic [CKS_W-1:0]         checksum
`endif
);

   estado_t           estado, estado_nx;
   logic [MAT_W-1:0]  buffer;
   logic [2:0]        linha, linha_nx;
   logic [2:0]        coluna, coluna_nx;
   logic [2:0]        n_reg, n_nx;
   logic [2:0]        n_m1;
   logic              erro_r, erro_nx;
   logic              tam_ok;
   logic              capture;
   logic              xfer;
   logic              last_elem;
   logic signed [ELEM_W-1:0] elem;

   matriz_elem_sel u_sel (
      .buffer (buffer),
      .linha  (linha),
      .coluna (coluna),
      .elem   (elem)
   );

   assign n_m1   = n_reg - 3'd1;
   assign tam_ok = (tamanho != 8'd0) && (tamanho <= 8'(DIM));

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         estado <= IDLE;
         linha  <= 3'd0;
         coluna <= 3'd0;
         n_reg  <= 3'd0;
         erro_r <= 1'b0;
      end else begin
         estado <= estado_nx;
         linha  <= linha_nx;
         coluna <= coluna_nx;
         n_reg  <= n_nx;
         erro_r <= erro_nx;
      end
   end

   // Matrix storage is data only; outputs are gated by state so it needs no reset.
   always_ff @(posedge clock) begin
      if (capture) begin
         buffer <= matriz_in;
      end
   end

   always_comb begin
      estado_nx  = estado;
      linha_nx   = linha;
      coluna_nx  = coluna;
      n_nx       = n_reg;
      erro_nx    = 1'b0;
      capture    = 1'b0;
      xfer       = (estado == SEND) && out_ready;
      last_elem  = (linha == n_m1) && (coluna == n_m1);
      busy       = 1'b0;
      out_valid  = 1'b0;
      out_data   = '0;
      out_linha  = 3'd0;
      out_coluna = 3'd0;
      out_last   = 1'b0;
      done       = erro_r;
      erro       = erro_r;

      case (estado)
         IDLE: begin
            if (start) begin
               if (tam_ok) begin
                  capture   = 1'b1;
                  n_nx      = tamanho[2:0];
                  linha_nx  = 3'd0;
                  coluna_nx = 3'd0;
                  estado_nx = SEND;
               end else begin
                  erro_nx = 1'b1;
               end
            end
         end
         SEND: begin
            busy       = 1'b1;
            out_valid  = 1'b1;
            out_data   = elem;
            out_linha  = linha;
            out_coluna = coluna;
            out_last   = last_elem;
            if (xfer) begin
               if (last_elem) begin
                  estado_nx = FIM;
               end else if (coluna == n_m1) begin
                  coluna_nx = 3'd0;
                  linha_nx  = linha + 3'd1;
               end else begin
                  coluna_nx = coluna + 3'd1;
               end
            end
         end
         FIM: begin
            done      = 1'b1;
            estado_nx = IDLE;
         end
         default: begin
            estado_nx = IDLE;
         end
      endcase
   end

`ifdef CHECKSUM_EN
   // Sign-extended running sum; holds after the last transfer until the next capture.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         checksum <= '0;
      end else if (capture) begin
         checksum <= '0;
      end else if (xfer) begin
         checksum <= checksum + {{(CKS_W-ELEM_W){elem[ELEM_W-1]}}, elem};
      end
   end
`endif

endmodule

// File: tb/tb_matriz_leitor_serial.sv
// Directed bench for matriz_leitor_serial; build with CHECKSUM_EN defined to cover the checksum port.
module tb_matriz_leitor_serial;

   logic              clock = 1'b0;
   logic              reset_n = 1'b0;
   logic              start = 1'b0;
   logic [199:0]      matriz_in = '0;
   logic [7:0]        tamanho = 8'd0;
   logic              out_ready = 1'b0;
   logic              busy;
   logic              out_valid;
   logic signed [7:0] out_data;
   logic [2:0]        out_linha;
   logic [2:0]        out_coluna;
   logic              out_last;
   logic              done;
   logic              erro;
`ifdef CHECKSUM_EN
   logic [15:0]       checksum;
`endif

   int checks = 0;
   int failures = 0;

   matriz_leitor_serial dut (
      .clock      (clock),
      .reset_n    (reset_n),
      .start      (start),
      .matriz_in  (matriz_in),
      .tamanho    (tamanho),
      .busy       (busy),
      .out_valid  (out_valid),
      .out_ready  (out_ready),
      .out_data   (out_data),
      .out_linha  (out_linha),
      .out_coluna (out_coluna),
      .out_last   (out_last),
      .done       (done),
      .erro       (erro)
`ifdef CHECKSUM_EN
      ,
      .checksum   (checksum)
`endif
   );

   always #5 clock = ~clock;

   task automatic step();
      @(posedge clock);
      #1;
   endtask

   // Hand-chosen element values per stimulus set.
   function automatic int exp_val(input int kind, input int r, input int c);
      case (kind)
         0: return 5 * r + c - 12;
         1: return 10 * r + c;
         2: begin
            if (r < 2 && c < 2) return (2 * r + c + 1) * ((c == 1) ? -1 : 1);
            return 85;
         end
         3: begin
            if (r == 0 && c == 0) return -128;
            if (r == 0 && c == 1) return -1;
            if (r == 1 && c == 0) return 127;
            if (r == 1 && c == 1) return 2;
            return 99;
         end
         default: return 127;
      endcase
   endfunction

   function automatic logic [199:0] mat_build(input int kind);
      logic [199:0] m;
      m = '0;
      for (int k = 24; k >= 0; k--) begin
         m = {m[191:0], 8'(exp_val(kind, k / 5, k % 5))};
      end
      return m;
   endfunction

   task automatic test_reset();
      reset_n = 1'b0;
      tamanho = 8'd5;
      matriz_in = mat_build(0);
      out_ready = 1'b1;
      step();
      step();
      checks++;
      if ({busy, out_valid, out_data, out_linha, out_coluna, out_last, done, erro} !== 19'd0) begin
         failures++;
         $display("FAIL reset_idle got busy=%0b valid=%0b done=%0b erro=%0b required all 0", busy, out_valid, done, erro);
      end
      reset_n = 1'b1;
      step();
      start = 1'b1;
      step();
      start = 1'b0;
      for (int k = 0; k < 7; k++) begin
         checks++;
         if ({out_valid, out_data, out_linha, out_coluna} !== {1'b1, 8'(exp_val(0, k / 5, k % 5)), 3'(k / 5), 3'(k % 5)}) begin
            failures++;
            $display("FAIL reset_pre k=%0d got v=%0b d=%0d r=%0d c=%0d", k, out_valid, out_data, out_linha, out_coluna);
         end
         step();
      end
      reset_n = 1'b0;
      #1;
      checks++;
      if ({busy, out_valid, out_data, out_linha, out_coluna, out_last, done, erro} !== 19'd0) begin
         failures++;
         $display("FAIL reset_mid got busy=%0b valid=%0b d=%0d done=%0b required all 0", busy, out_valid, out_data, done);
      end
      step();
      step();
      reset_n = 1'b1;
      checks++;
      if ({busy, out_valid, done, erro} !== 4'b0000) begin
         failures++;
         $display("FAIL reset_hold got busy=%0b valid=%0b done=%0b erro=%0b required 0000", busy, out_valid, done, erro);
      end
      step();
      checks++;
      if ({busy, out_valid, done, erro} !== 4'b0000) begin
         failures++;
         $display("FAIL reset_release got busy=%0b valid=%0b done=%0b erro=%0b required 0000", busy, out_valid, done, erro);
      end
      start = 1'b1;
      step();
      start = 1'b0;
      for (int k = 0; k < 25; k++) begin
         checks++;
         if ({out_valid, out_data, out_linha, out_coluna, out_last} !== {1'b1, 8'(exp_val(0, k / 5, k % 5)), 3'(k / 5), 3'(k % 5), k == 24}) begin
            failures++;
            $display("FAIL restart k=%0d got v=%0b d=%0d r=%0d c=%0d l=%0b", k, out_valid, out_data, out_linha, out_coluna, out_last);
         end
         step();
      end
      checks++;
      if ({busy, out_valid, done, erro} !== 4'b0010) begin
         failures++;
         $display("FAIL restart_done got busy=%0b valid=%0b done=%0b erro=%0b required 0010", busy, out_valid, done, erro);
      end
      step();
   endtask

   task automatic test_full();
      tamanho = 8'd5;
      matriz_in = mat_build(0);
      out_ready = 1'b1;
      start = 1'b1;
      step();
      start = 1'b0;
      for (int k = 0; k < 25; k++) begin
         checks++;
         if ({busy, out_valid, out_data, out_linha, out_coluna, out_last, done} !== {2'b11, 8'(5 * (k / 5) + (k % 5) - 12), 3'(k / 5), 3'(k % 5), k == 24, 1'b0}) begin
            failures++;
            $display("FAIL full k=%0d got b=%0b v=%0b d=%0d r=%0d c=%0d l=%0b done=%0b required d=%0d", k, busy, out_valid, out_data, out_linha, out_coluna, out_last, done, k - 12);
         end
         step();
      end
      checks++;
      if ({busy, out_valid, done, erro} !== 4'b0010) begin
         failures++;
         $display("FAIL full_done got busy=%0b valid=%0b done=%0b erro=%0b required 0010", busy, out_valid, done, erro);
      end
      step();
      checks++;
      if ({busy, out_valid, done, erro} !== 4'b0000) begin
         failures++;
         $display("FAIL full_after got busy=%0b valid=%0b done=%0b erro=%0b required 0000", busy, out_valid, done, erro);
      end
   endtask

   task automatic test_backpressure();
      int k;
      int t;
      tamanho = 8'd3;
      matriz_in = mat_build(1);
      out_ready = 1'b1;
      start = 1'b1;
      step();
      start = 1'b0;
      k = 0;
      t = 0;
      while (k < 9 && t < 60) begin
         checks++;
         if ({out_valid, out_data, out_linha, out_coluna, out_last, done} !== {1'b1, 8'(10 * (k / 3) + (k % 3)), 3'(k / 3), 3'(k % 3), k == 8, 1'b0}) begin
            failures++;
            $display("FAIL bp t=%0d k=%0d got v=%0b d=%0d r=%0d c=%0d l=%0b required d=%0d r=%0d c=%0d", t, k, out_valid, out_data, out_linha, out_coluna, out_last, 10 * (k / 3) + (k % 3), k / 3, k % 3);
         end
         out_ready = (t % 3 == 0);
         step();
         if (out_ready) k++;
         t++;
      end
      checks++;
      if (k != 9) begin
         failures++;
         $display("FAIL bp_bound got transfers=%0d required 9", k);
      end
      out_ready = 1'b0;
      checks++;
      if ({busy, out_valid, done, erro} !== 4'b0010) begin
         failures++;
         $display("FAIL bp_done got busy=%0b valid=%0b done=%0b erro=%0b required 0010", busy, out_valid, done, erro);
      end
      step();
      out_ready = 1'b1;
      step();
      checks++;
      if ({busy, out_valid, done} !== 3'b000) begin
         failures++;
         $display("FAIL bp_idle_ready got busy=%0b valid=%0b done=%0b required 000", busy, out_valid, done);
      end
   endtask

   task automatic test_invalid();
      for (int i = 0; i < 2; i++) begin
         tamanho = (i == 0) ? 8'd0 : 8'd6;
         start = 1'b1;
         step();
         start = 1'b0;
         checks++;
         if ({busy, out_valid, done, erro} !== 4'b0011) begin
            failures++;
            $display("FAIL invalid_pulse tam=%0d got busy=%0b valid=%0b done=%0b erro=%0b required 0011", tamanho, busy, out_valid, done, erro);
         end
         step();
         checks++;
         if ({busy, out_valid, done, erro} !== 4'b0000) begin
            failures++;
            $display("FAIL invalid_after tam=%0d got busy=%0b valid=%0b done=%0b erro=%0b required 0000", tamanho, busy, out_valid, done, erro);
         end
      end
   endtask

   task automatic test_ignored_start();
      tamanho = 8'd2;
      matriz_in = mat_build(2);
      out_ready = 1'b1;
      start = 1'b1;
      step();
      start = 1'b0;
      for (int k = 0; k < 4; k++) begin
         checks++;
         if ({busy, out_valid, out_data, out_linha, out_coluna, out_last} !== {2'b11, 8'(exp_val(2, k / 2, k % 2)), 3'(k / 2), 3'(k % 2), k == 3}) begin
            failures++;
            $display("FAIL isolate k=%0d got b=%0b v=%0b d=%0d r=%0d c=%0d l=%0b required d=%0d", k, busy, out_valid, out_data, out_linha, out_coluna, out_last, exp_val(2, k / 2, k % 2));
         end
         if (k == 0) begin
            matriz_in = {25{8'h7F}};
            tamanho = 8'd5;
            start = 1'b1;
         end else begin
            start = 1'b0;
         end
         step();
      end
      checks++;
      if ({busy, out_valid, done, erro} !== 4'b0010) begin
         failures++;
         $display("FAIL isolate_done got busy=%0b valid=%0b done=%0b erro=%0b required 0010", busy, out_valid, done, erro);
      end
      step();
   endtask

`ifdef CHECKSUM_EN
   task automatic test_checksum();
      tamanho = 8'd2;
      matriz_in = mat_build(3);
      out_ready = 1'b1;
      start = 1'b1;
      step();
      start = 1'b0;
      for (int k = 0; k < 4; k++) begin
         if (k == 1) begin
            checks++;
            if (checksum !== 16'hFF80) begin
               failures++;
               $display("FAIL cks_partial got %h required ff80", checksum);
            end
         end
         step();
      end
      checks++;
      if ({done, checksum} !== {1'b1, 16'h0000}) begin
         failures++;
         $display("FAIL cks_small got done=%0b cks=%h required done=1 cks=0000", done, checksum);
      end
      step();
      tamanho = 8'd5;
      matriz_in = mat_build(4);
      start = 1'b1;
      step();
      start = 1'b0;
      for (int k = 0; k < 25; k++) step();
      checks++;
      if ({done, checksum} !== {1'b1, 16'h0C67}) begin
         failures++;
         $display("FAIL cks_full got done=%0b cks=%h required done=1 cks=0c67", done, checksum);
      end
      step();
      checks++;
      if (checksum !== 16'h0C67) begin
         failures++;
         $display("FAIL cks_hold got %h required 0c67", checksum);
      end
   endtask
`endif

   initial begin
      test_reset();
      test_full();
      test_backpressure();
      test_invalid();
      test_ignored_start();
`ifdef CHECKSUM_EN
      test_checksum();
`endif
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog expired checks=%0d", checks);
      $fatal(1, "watchdog");
   end

endmodule
